ext_mem_model: RTL and testbench

Parametrised multi-channel external-memory model that sits beside `main` in the HLS simulation harness. It serves the master memory ports (oe/we/addr/wdata/size per channel) from a byte-addressed array mapped at a configurable base address. Each channel has its own read/write latency counter and a one-cycle `data_rdy` handshake. Over the previous fixed two-channel model it adds:

- arbitrary channel count and data width;
- multi-byte little-endian accesses;
- a preload port;
- deterministic same-cycle write collision resolution;
- per-channel protocol-error flags.

---
 rtl/ext_mem_model_if.sv | 29 ++
 rtl/ext_mem_model.sv | 138 +++++++++++++
 tb/tb_ext_mem_model.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/ext_mem_model_if.sv
// rtl/ext_mem_model_if.sv - master-port bundle between the HLS harness and the external memory model
interface ext_mem_model_if #(
  parameter int CHANNELS = 2,
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 11,
  parameter int SIZE_W   = 5
);
  logic [CHANNELS-1:0]        oe;
  logic [CHANNELS-1:0]        we;
  logic [CHANNELS*ADDR_W-1:0] addr;
  logic [CHANNELS*DATA_W-1:0] wdata;
  logic [CHANNELS*SIZE_W-1:0] size;
  logic                       init_we;
  logic [ADDR_W-1:0]          init_addr;
  logic [7:0]                 init_data;
  logic [CHANNELS*DATA_W-1:0] rdata;
  logic [CHANNELS-1:0]        data_rdy;
  logic [CHANNELS-1:0]        err;

  modport master (
    output oe, we, addr, wdata, size, init_we, init_addr, init_data,
    input  rdata, data_rdy, err
  );

  modport slave (
    input  oe, we, addr, wdata, size, init_we, init_addr, init_data,
    output rdata, data_rdy, err
  );
endinterface

// File: rtl/ext_mem_model.sv
// rtl/ext_mem_model.sv - multi-channel byte-addressed external memory model with per-channel latency FSMs
module ext_mem_model #(
  parameter int CHANNELS  = 2,
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 11,
  parameter int SIZE_W    = 5,
  parameter int MEMSIZE   = 256,
  parameter int BASE_ADDR = 0,
  parameter int RD_LAT    = 2,
  parameter int WR_LAT    = 1
) (
  input logic           clock,
  input logic           reset,
  ext_mem_model_if.slave bus
);
  localparam int NB      = DATA_W / 8;
  localparam int MIDX_W  = (MEMSIZE > 1) ? $clog2(MEMSIZE) : 1;
  localparam int LAT_MAX = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
  localparam int CNT_W   = (LAT_MAX > 1) ? $clog2(LAT_MAX + 1) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Byte array kept as one packed vector so looped byte writes stay simple.
  logic [MEMSIZE*8-1:0] mem;

  logic [CHANNELS-1:0] idle;
  logic [CHANNELS-1:0] in_win;
  logic [CHANNELS-1:0] rd_acc;
  logic [CHANNELS-1:0] wr_acc;
  logic [CHANNELS-1:0] conflict;
  logic [MIDX_W-1:0]   base_idx [CHANNELS];
  logic [DATA_W-1:0]   mask     [CHANNELS];
  logic [DATA_W-1:0]   rd_word  [CHANNELS];
  logic                init_hit;
  logic [MIDX_W-1:0]   init_idx;

  // Decode window, acceptance, size mask and the little-endian read word for every channel.
  always_comb begin
    logic [31:0] a_ext;
    logic [31:0] i_ext;
    logic [SIZE_W-1:0] sz;
    in_win   = '0;
    rd_acc   = '0;
    wr_acc   = '0;
    conflict = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      a_ext       = 32'(bus.addr[i*ADDR_W +: ADDR_W]);
      sz          = bus.size[i*SIZE_W +: SIZE_W];
      in_win[i]   = (a_ext >= 32'(BASE_ADDR)) &&
                    (a_ext + 32'(NB) <= 32'(BASE_ADDR) + 32'(MEMSIZE));
      base_idx[i] = MIDX_W'(a_ext - 32'(BASE_ADDR));
      // Accepting only while reset is high keeps the array untouched during reset.
      rd_acc[i]   = reset && idle[i] && in_win[i] && bus.oe[i] && !bus.we[i];
      wr_acc[i]   = reset && idle[i] && in_win[i] && bus.we[i] && !bus.oe[i];
      conflict[i] = idle[i] && in_win[i] && bus.oe[i] && bus.we[i];
      mask[i]     = '0;
      rd_word[i]  = '0;
      for (int k = 0; k < DATA_W; k++) begin
        mask[i][k] = (32'(k) < 32'(sz));
      end
      if (in_win[i]) begin
        for (int b = 0; b < NB; b++) begin
          rd_word[i][b*8 +: 8] = mem[(int'(base_idx[i]) + b)*8 +: 8];
        end
      end
    end
    i_ext    = 32'(bus.init_addr);
    init_hit = bus.init_we && (i_ext >= 32'(BASE_ADDR)) &&
               (i_ext < 32'(BASE_ADDR) + 32'(MEMSIZE));
    init_idx = MIDX_W'(i_ext - 32'(BASE_ADDR));
  end

  // Array update: ascending channel order lets the highest index win, preload lands last of all.
  always_ff @(posedge clock) begin
    for (int i = 0; i < CHANNELS; i++) begin
      if (wr_acc[i]) begin
        for (int b = 0; b < NB; b++) begin
          mem[(int'(base_idx[i]) + b)*8 +: 8] <=
            (mem[(int'(base_idx[i]) + b)*8 +: 8] & ~mask[i][b*8 +: 8]) |
            (bus.wdata[i*DATA_W + b*8 +: 8] & mask[i][b*8 +: 8]);
        end
      end
    end
    if (init_hit) begin
      mem[int'(init_idx)*8 +: 8] <= bus.init_data;
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic [1:0]       state;
    logic [CNT_W-1:0] count;
    logic [DATA_W-1:0] rbuf;
    logic             err_q;

    // Channel FSM: capture read data at acceptance, count the latency, pulse DONE for one cycle.
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        state <= S_IDLE;
        count <= '0;
        rbuf  <= '0;
        err_q <= 1'b0;
      end else begin
        if (conflict[g]) err_q <= 1'b1;
        case (state)
          S_IDLE: begin
            if (rd_acc[g]) begin
              rbuf <= rd_word[g] & mask[g];
              if (RD_LAT <= 1) state <= S_DONE;
              else begin
                state <= S_BUSY;
                count <= CNT_W'(RD_LAT - 1);
              end
            end else if (wr_acc[g]) begin
              rbuf <= '0;
              if (WR_LAT <= 1) state <= S_DONE;
              else begin
                state <= S_BUSY;
                count <= CNT_W'(WR_LAT - 1);
              end
            end
          end
          S_BUSY: begin
            count <= count - CNT_W'(1);
            if (count <= CNT_W'(1)) state <= S_DONE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end

    assign idle[g]                         = (state == S_IDLE);
    assign bus.data_rdy[g]                 = (state == S_DONE);
    assign bus.rdata[g*DATA_W +: DATA_W]   = (state == S_DONE) ? rbuf : '0;
    assign bus.err[g]                      = err_q;
  end
endmodule

// File: tb/tb_ext_mem_model.sv
// tb/tb_ext_mem_model.sv - directed self-checking bench for ext_mem_model
module tb_ext_mem_model;
  localparam int BASE = 256;

  logic clock = 1'b0;
  logic reset;
  int   n_pass  = 0;
  int   n_total = 0;

  ext_mem_model_if #(.CHANNELS(2), .DATA_W(16), .ADDR_W(11), .SIZE_W(5)) bus ();

  ext_mem_model #(
    .CHANNELS(2), .DATA_W(16), .ADDR_W(11), .SIZE_W(5),
    .MEMSIZE(256), .BASE_ADDR(BASE), .RD_LAT(2), .WR_LAT(1)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  always #5 clock = ~clock;

  task automatic clear_bus();
    bus.oe = '0; bus.we = '0; bus.addr = '0; bus.wdata = '0; bus.size = '0;
    bus.init_we = 1'b0; bus.init_addr = '0; bus.init_data = '0;
  endtask

  task automatic preload(input logic [10:0] a, input logic [7:0] d);
    bus.init_we = 1'b1; bus.init_addr = a; bus.init_data = d;
    @(negedge clock);
    bus.init_we = 1'b0;
  endtask

  task automatic access(input int ch, input bit wr, input logic [10:0] a, input logic [15:0] d,
                        input logic [4:0] s, output logic [15:0] got, output int lat, output int pulses);
    got = '0; lat = -1; pulses = 0;
    bus.addr[ch*11 +: 11] = a; bus.wdata[ch*16 +: 16] = d; bus.size[ch*5 +: 5] = s;
    if (wr) bus.we[ch] = 1'b1; else bus.oe[ch] = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clock);
      if (n == 1) begin bus.oe[ch] = 1'b0; bus.we[ch] = 1'b0; end
      if (bus.data_rdy[ch]) begin
        pulses++;
        if (lat < 0) begin lat = n; got = bus.rdata[ch*16 +: 16]; end
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; clear_bus();
    repeat (2) @(negedge clock);
    n_total++; if (bus.data_rdy !== 2'b00) $display("FAIL reset_rdy: got %b expected 00", bus.data_rdy); else n_pass++;
    n_total++; if (bus.rdata !== 32'h0) $display("FAIL reset_rdata: got %h expected 0", bus.rdata); else n_pass++;
    n_total++; if (bus.err !== 2'b00) $display("FAIL reset_err: got %b expected 00", bus.err); else n_pass++;
    reset = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_preload_read();
    logic [15:0] got; int lat, p;
    preload(11'(BASE), 8'h34);
    preload(11'(BASE + 1), 8'h12);
    access(0, 1'b0, 11'(BASE), 16'h0, 5'd16, got, lat, p);
    n_total++; if (got !== 16'h1234) $display("FAIL read_data: got %h expected 1234", got); else n_pass++;
    n_total++; if (lat !== 2) $display("FAIL read_latency: got %0d expected 2", lat); else n_pass++;
    n_total++; if (p !== 1) $display("FAIL read_pulses: got %0d expected 1", p); else n_pass++;
  endtask

  task automatic test_partial_write();
    logic [15:0] got; int lat, p;
    preload(11'(BASE + 4), 8'hFF);
    preload(11'(BASE + 5), 8'hFF);
    access(1, 1'b1, 11'(BASE + 4), 16'hABCD, 5'd8, got, lat, p);
    n_total++; if (lat !== 1) $display("FAIL write_latency: got %0d expected 1", lat); else n_pass++;
    n_total++; if (p !== 1) $display("FAIL write_pulses: got %0d expected 1", p); else n_pass++;
    access(1, 1'b0, 11'(BASE + 4), 16'h0, 5'd16, got, lat, p);
    n_total++; if (got !== 16'hFFCD) $display("FAIL partial_write: got %h expected ffcd", got); else n_pass++;
    access(0, 1'b0, 11'(BASE + 4), 16'h0, 5'd4, got, lat, p);
    n_total++; if (got !== 16'h000D) $display("FAIL read_size4: got %h expected 000d", got); else n_pass++;
  endtask

  task automatic test_collision();
    logic [15:0] got, old; int lat, p;
    bus.addr = {11'(BASE + 8), 11'(BASE + 8)}; bus.wdata = {16'h0022, 16'h0011}; bus.size = {5'd8, 5'd8};
    bus.we = 2'b11;
    @(negedge clock);
    bus.we = 2'b00;
    repeat (3) @(negedge clock);
    access(0, 1'b0, 11'(BASE + 8), 16'h0, 5'd8, got, lat, p);
    n_total++; if (got !== 16'h0022) $display("FAIL chan_collision: got %h expected 0022", got); else n_pass++;
    bus.addr = {11'(BASE + 8), 11'(BASE + 8)}; bus.wdata = {16'h0022, 16'h0011}; bus.size = {5'd8, 5'd8};
    bus.we = 2'b11; bus.init_we = 1'b1; bus.init_addr = 11'(BASE + 8); bus.init_data = 8'h33;
    @(negedge clock);
    bus.we = 2'b00; bus.init_we = 1'b0;
    repeat (3) @(negedge clock);
    access(1, 1'b0, 11'(BASE + 8), 16'h0, 5'd8, got, lat, p);
    n_total++; if (got !== 16'h0033) $display("FAIL init_collision: got %h expected 0033", got); else n_pass++;
    old = 16'hDEAD;
    bus.addr = {11'(BASE + 8), 11'(BASE + 8)}; bus.wdata = {16'h0044, 16'h0000}; bus.size = {5'd8, 5'd8};
    bus.oe = 2'b01; bus.we = 2'b10;
    for (int n = 1; n <= 4; n++) begin
      @(negedge clock);
      if (n == 1) begin bus.oe = 2'b00; bus.we = 2'b00; end
      if (bus.data_rdy[0]) old = bus.rdata[15:0];
    end
    n_total++; if (old !== 16'h0033) $display("FAIL read_during_write: got %h expected 0033", old); else n_pass++;
    access(0, 1'b0, 11'(BASE + 8), 16'h0, 5'd8, got, lat, p);
    n_total++; if (got !== 16'h0044) $display("FAIL write_after_rdw: got %h expected 0044", got); else n_pass++;
  endtask

  task automatic test_out_of_window();
    logic [15:0] got; int lat, p; int bad;
    bad = 0;
    bus.addr[10:0] = 11'(BASE + 255); bus.size[4:0] = 5'd16; bus.oe[0] = 1'b1;
    repeat (10) begin
      @(negedge clock);
      if (bus.data_rdy[0] !== 1'b0 || bus.rdata[15:0] !== 16'h0) bad++;
    end
    bus.oe[0] = 1'b0;
    n_total++; if (bad !== 0) $display("FAIL window_top: got %0d bad cycles expected 0", bad); else n_pass++;
    bad = 0;
    bus.addr[10:0] = 11'(BASE - 1); bus.oe[0] = 1'b1; bus.we[0] = 1'b1;
    repeat (5) begin
      @(negedge clock);
      if (bus.data_rdy[0] !== 1'b0 || bus.err[0] !== 1'b0) bad++;
    end
    bus.oe[0] = 1'b0; bus.we[0] = 1'b0;
    n_total++; if (bad !== 0) $display("FAIL window_below: got %0d bad cycles expected 0", bad); else n_pass++;
    access(0, 1'b0, 11'(BASE + 254), 16'h0, 5'd16, got, lat, p);
    n_total++; if (lat !== 2) $display("FAIL window_edge_accept: got latency %0d expected 2", lat); else n_pass++;
  endtask

  task automatic test_conflict();
    int bad;
    bus.addr[10:0] = 11'(BASE); bus.size[4:0] = 5'd16; bus.oe[0] = 1'b1; bus.we[0] = 1'b1;
    @(negedge clock);
    n_total++; if (bus.err[0] !== 1'b1) $display("FAIL conflict_err: got %b expected 1", bus.err[0]); else n_pass++;
    bus.oe[0] = 1'b0; bus.we[0] = 1'b0;
    bad = 0;
    repeat (5) begin
      @(negedge clock);
      if (bus.data_rdy !== 2'b00) bad++;
    end
    n_total++; if (bad !== 0) $display("FAIL conflict_rdy: got %0d pulses expected 0", bad); else n_pass++;
    n_total++; if (bus.err !== 2'b01) $display("FAIL conflict_sticky: got %b expected 01", bus.err); else n_pass++;
    reset = 1'b0;
    @(negedge clock);
    n_total++; if (bus.err !== 2'b00) $display("FAIL conflict_reset: got %b expected 00", bus.err); else n_pass++;
    reset = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_back_to_back();
    int first, last, cnt, gap_bad, data_bad;
    first = -1; last = -1; cnt = 0; gap_bad = 0; data_bad = 0;
    bus.addr[10:0] = 11'(BASE); bus.size[4:0] = 5'd16; bus.oe[0] = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clock);
      if (bus.data_rdy[0]) begin
        cnt++;
        if (bus.rdata[15:0] !== 16'h1234) data_bad++;
        if (last >= 0 && n - last != 3) gap_bad++;
        if (first < 0) first = n;
        last = n;
      end
    end
    bus.oe[0] = 1'b0;
    repeat (4) @(negedge clock);
    n_total++; if (first !== 2) $display("FAIL b2b_first: got %0d expected 2", first); else n_pass++;
    n_total++; if (cnt !== 4) $display("FAIL b2b_count: got %0d expected 4", cnt); else n_pass++;
    n_total++; if (gap_bad !== 0) $display("FAIL b2b_spacing: got %0d bad gaps expected 0", gap_bad); else n_pass++;
    n_total++; if (data_bad !== 0) $display("FAIL b2b_data: got %0d bad words expected 0", data_bad); else n_pass++;
  endtask

  task automatic test_reset_mid_busy();
    logic [15:0] got; int lat, p, pulses;
    pulses = 0;
    bus.addr[10:0] = 11'(BASE); bus.size[4:0] = 5'd16; bus.oe[0] = 1'b1;
    @(negedge clock);
    bus.oe[0] = 1'b0;
    reset = 1'b0;
    repeat (3) begin @(negedge clock); if (bus.data_rdy[0]) pulses++; end
    reset = 1'b1;
    repeat (3) begin @(negedge clock); if (bus.data_rdy[0]) pulses++; end
    n_total++; if (pulses !== 0) $display("FAIL abort_pulse: got %0d expected 0", pulses); else n_pass++;
    access(0, 1'b0, 11'(BASE), 16'h0, 5'd16, got, lat, p);
    n_total++; if (lat !== 2) $display("FAIL after_abort_latency: got %0d expected 2", lat); else n_pass++;
    n_total++; if (got !== 16'h1234) $display("FAIL after_abort_data: got %h expected 1234", got); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_preload_read();
    test_partial_write();
    test_collision();
    test_out_of_window();
    test_conflict();
    test_back_to_back();
    test_reset_mid_busy();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
